// File: rtl/uart_mike_frame_ctrl.sv
// Half-duplex UART frame controller: TX serialiser paced by baud_tick plus RX handshake sequencing.
// Optional line-break generator enabled by defining UART_MIKE_TX_BREAK_EN.
module uart_mike_frame_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_MODE = 0
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  baud_tick,
    input  logic                  tx_send,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  rx_start,
    input  logic                  rx_done,
    input  logic                  rx_flag_clr,
`ifdef UART_MIKE_TX_BREAK_EN
    input  logic                  tx_break,
`endif
    output logic                  tx_line,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  rx_busy,
    output logic                  rx_flag,
    output logic [2:0]            state_dbg
);

    if ((DATA_WIDTH < 5) || (DATA_WIDTH > 9) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
        (PARITY_MODE < 0) || (PARITY_MODE > 2)) begin : g_param_err
        $error("uart_mike_frame_ctrl: illegal DATA_WIDTH/STOP_BITS/PARITY_MODE");
    end

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RX_DATA      = 3'd1,
        WAIT_FLG_CLR = 3'd2,
        TX_START     = 3'd3,
        TX_DATA      = 3'd4,
        TX_PARITY    = 3'd5,
        TX_STOP      = 3'd6,
        TX_BREAK     = 3'd7
    } state_t;

    localparam logic [3:0] LAST_BIT  = 4'(DATA_WIDTH - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic       ODD_PAR   = (PARITY_MODE == 2);

    state_t                r_state, w_nstate;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic                  r_par, w_par_nxt;
    logic [3:0]            r_bit_cnt, w_bit_cnt_nxt;
    logic                  r_stop_cnt, w_stop_cnt_nxt;
    logic                  r_tx_line, r_tx_busy, r_tx_done, r_rx_busy, r_rx_flag;
    logic                  w_line_nxt, w_done_nxt, w_brk;

`ifdef UART_MIKE_TX_BREAK_EN
    assign w_brk = tx_break;
`else
    assign w_brk = 1'b0;
`endif

    always_comb begin
        w_nstate       = r_state;
        w_shift_nxt    = r_shift;
        w_par_nxt      = r_par;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_done_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_start) begin
                    w_nstate = RX_DATA;
                end else if (w_brk) begin
                    w_nstate = TX_BREAK;
                end else if (tx_send && baud_tick) begin
                    w_shift_nxt = tx_data;
                    w_par_nxt   = (^tx_data) ^ ODD_PAR;
                    w_nstate    = TX_START;
                end
            end
            RX_DATA:      if (rx_done)     w_nstate = WAIT_FLG_CLR;
            WAIT_FLG_CLR: if (rx_flag_clr) w_nstate = IDLE;
            TX_START:     if (baud_tick)   w_nstate = TX_DATA;
            TX_DATA: begin
                if (baud_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_bit_cnt_nxt = 4'd0;
                        w_nstate      = (PARITY_MODE != 0) ? TX_PARITY : TX_STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end
            end
            TX_PARITY:    if (baud_tick)   w_nstate = TX_STOP;
            TX_STOP: begin
                if (baud_tick) begin
                    if (r_stop_cnt == LAST_STOP) begin
                        w_stop_cnt_nxt = 1'b0;
                        w_done_nxt     = 1'b1;
                        w_nstate       = IDLE;
                    end else begin
                        w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                    end
                end
            end
            TX_BREAK:     if (!w_brk)      w_nstate = IDLE;
            default:                       w_nstate = IDLE;
        endcase
    end

    // Line level is derived from the next state so every output comes straight from a flop.
    always_comb begin
        w_line_nxt = 1'b1;
        case (w_nstate)
            TX_START, TX_BREAK: w_line_nxt = 1'b0;
            TX_DATA:            w_line_nxt = w_shift_nxt[0];
            TX_PARITY:          w_line_nxt = w_par_nxt;
            default:            w_line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_bit_cnt  <= 4'd0;
            r_stop_cnt <= 1'b0;
            r_tx_line  <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
            r_rx_busy  <= 1'b0;
            r_rx_flag  <= 1'b0;
        end else begin
            r_state    <= w_nstate;
            r_shift    <= w_shift_nxt;
            r_par      <= w_par_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_tx_line  <= w_line_nxt;
            r_tx_busy  <= (w_nstate inside {TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_BREAK});
            r_tx_done  <= w_done_nxt;
            r_rx_busy  <= (w_nstate == RX_DATA);
            r_rx_flag  <= (w_nstate == WAIT_FLG_CLR);
        end
    end

    assign tx_line   = r_tx_line;
    assign tx_busy   = r_tx_busy;
    assign tx_done   = r_tx_done;
    assign rx_busy   = r_rx_busy;
    assign rx_flag   = r_rx_flag;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_uart_mike_frame_ctrl.sv
// Directed bench: two instances (8N1 and 7O2) driven from a frame table plus hand-written sequences.
module tb_uart_mike_frame_ctrl;

    logic       clk = 1'b0, n_rst = 1'b0, baud_tick = 1'b0;
    logic       send0 = 1'b0, send1 = 1'b0;
    logic [7:0] data0 = '0;
    logic [6:0] data1 = '0;
    logic       rxs = 1'b0, rxd = 1'b0, rxc = 1'b0;
    logic       line0, busy0, done0, rxb0, rxf0;
    logic       line1, busy1, done1, rxb1, rxf1;
    logic [2:0] st0, st1;
`ifdef UART_MIKE_TX_BREAK_EN
    logic       brk = 1'b0;
`endif

    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    uart_mike_frame_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1), .PARITY_MODE(0)) dut0 (
        .clk(clk), .n_rst(n_rst), .baud_tick(baud_tick), .tx_send(send0), .tx_data(data0),
        .rx_start(rxs), .rx_done(rxd), .rx_flag_clr(rxc),
`ifdef UART_MIKE_TX_BREAK_EN
        .tx_break(brk),
`endif
        .tx_line(line0), .tx_busy(busy0), .tx_done(done0), .rx_busy(rxb0), .rx_flag(rxf0),
        .state_dbg(st0));

    uart_mike_frame_ctrl #(.DATA_WIDTH(7), .STOP_BITS(2), .PARITY_MODE(2)) dut1 (
        .clk(clk), .n_rst(n_rst), .baud_tick(baud_tick), .tx_send(send1), .tx_data(data1),
        .rx_start(1'b0), .rx_done(1'b0), .rx_flag_clr(1'b0),
`ifdef UART_MIKE_TX_BREAK_EN
        .tx_break(1'b0),
`endif
        .tx_line(line1), .tx_busy(busy1), .tx_done(done1), .rx_busy(rxb1), .rx_flag(rxf1),
        .state_dbg(st1));

    typedef struct {
        bit          sel;   // 0: 8N1 instance, 1: 7O2 instance
        logic [8:0]  data;
        int          len;   // ticks from acceptance to the last stop bit
        logic [15:0] bits;  // bits[i] = tx_line after tick i (tick 0 accepts)
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        repeat (2) @(negedge clk);
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
    endtask

    function automatic int line_of(input bit s);  return s ? int'(line1) : int'(line0); endfunction
    function automatic int busy_of(input bit s);  return s ? int'(busy1) : int'(busy0); endfunction
    function automatic int done_of(input bit s);  return s ? int'(done1) : int'(done0); endfunction

    task automatic run_frame(input vec_t v);
        if (v.sel) begin send1 = 1'b1; data1 = v.data[6:0]; end
        else       begin send0 = 1'b1; data0 = v.data[7:0]; end
        for (int i = 0; i < v.len; i++) begin
            tick();
            if (i == 0) begin
                // payload changes after acceptance must not leak into the frame
                send0 = 1'b0; send1 = 1'b0; data0 = ~data0; data1 = ~data1;
            end
            chk($sformatf("frame%0d_%h_bit%0d", v.sel, v.data, i), line_of(v.sel), int'(v.bits[i]));
            chk($sformatf("frame%0d_%h_busy%0d", v.sel, v.data, i), busy_of(v.sel), 1);
        end
        tick();
        chk($sformatf("frame%0d_%h_done", v.sel, v.data), done_of(v.sel), 1);
        chk($sformatf("frame%0d_%h_idle_line", v.sel, v.data), line_of(v.sel), 1);
        chk($sformatf("frame%0d_%h_busy_end", v.sel, v.data), busy_of(v.sel), 0);
        @(negedge clk);
        chk($sformatf("frame%0d_%h_done_pulse", v.sel, v.data), done_of(v.sel), 0);
    endtask

    initial begin
        vt[0] = '{sel: 1'b0, data: 9'h0A5, len: 10, bits: 16'b1101001010};
        vt[1] = '{sel: 1'b0, data: 9'h000, len: 10, bits: 16'b1000000000};
        vt[2] = '{sel: 1'b0, data: 9'h0FF, len: 10, bits: 16'b1111111110};
        vt[3] = '{sel: 1'b1, data: 9'h003, len: 11, bits: 16'b11100000110};
        vt[4] = '{sel: 1'b1, data: 9'h055, len: 11, bits: 16'b11110101010};
        vt[5] = '{sel: 1'b1, data: 9'h007, len: 11, bits: 16'b11000001110};

        repeat (3) @(negedge clk);
        chk("rst_line", line0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_rxb", rxb0, 0);
        chk("rst_rxf", rxf0, 0);
        chk("rst_state", st0, 0);
        n_rst = 1'b1;

        // tx_send alone does not start a frame
        send0 = 1'b1;
        repeat (3) @(negedge clk);
        chk("send_no_tick_state", st0, 0);
        chk("send_no_tick_line", line0, 1);

        // rx_start wins over tx_send+tick
        rxs = 1'b1; baud_tick = 1'b1;
        @(negedge clk);
        rxs = 1'b0; baud_tick = 1'b0; send0 = 1'b0;
        chk("rx_prio_state", st0, 1);
        chk("rx_prio_line", line0, 1);
        chk("rx_prio_rxbusy", rxb0, 1);
        chk("rx_prio_txbusy", busy0, 0);
        rxc = 1'b1;
        @(negedge clk);
        rxc = 1'b0;
        chk("rx_clr_ignored", st0, 1);
        rxd = 1'b1; rxc = 1'b1;
        @(negedge clk);
        rxd = 1'b0; rxc = 1'b0;
        chk("rx_done_clr_state", st0, 2);
        chk("rx_done_clr_flag", rxf0, 1);
        chk("rx_done_clr_rxbusy", rxb0, 0);
        rxs = 1'b1; send0 = 1'b1; baud_tick = 1'b1;
        @(negedge clk);
        rxs = 1'b0; send0 = 1'b0; baud_tick = 1'b0;
        chk("wait_ignores_state", st0, 2);
        chk("wait_ignores_busy", busy0, 0);
        rxc = 1'b1;
        @(negedge clk);
        rxc = 1'b0;
        chk("flag_clr_state", st0, 0);
        chk("flag_clr_flag", rxf0, 0);

        // asynchronous reset in the middle of data bit 3
        send0 = 1'b1; data0 = 8'hA5;
        tick();
        send0 = 1'b0;
        repeat (4) tick();
        chk("midrst_pre_state", st0, 4);
        chk("midrst_pre_line", line0, 0);
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("midrst_line", line0, 1);
        chk("midrst_busy", busy0, 0);
        chk("midrst_state", st0, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("midrst_no_done%0d", i), done0, 0);
        end

        for (int k = 0; k < 6; k++) run_frame(vt[k]);

        // tx_send held for two frames: one idle-high bit between them
        send0 = 1'b1; data0 = 8'h0F;
        for (int i = 0; i < 10; i++) tick();
        chk("b2b_f1_line", line0, 1);
        tick();
        chk("b2b_f1_done", done0, 1);
        chk("b2b_gap_line", line0, 1);
        chk("b2b_gap_state", st0, 0);
        tick();
        chk("b2b_f2_start_line", line0, 0);
        chk("b2b_f2_start_state", st0, 3);
        send0 = 1'b0;
        tick();
        chk("b2b_f2_bit0", line0, 1);
        for (int i = 0; i < 8; i++) tick();
        chk("b2b_f2_stop_line", line0, 1);
        chk("b2b_f2_not_done", done0, 0);
        tick();
        chk("b2b_f2_done", done0, 1);

`ifdef UART_MIKE_TX_BREAK_EN
        @(negedge clk);
        brk = 1'b1;
        @(negedge clk);
        chk("brk_state", st0, 7);
        chk("brk_busy", busy0, 1);
        for (int i = 0; i < 25; i++) begin
            tick();
            chk($sformatf("brk_line%0d", i), line0, 0);
        end
        brk = 1'b0;
        @(negedge clk);
        chk("brk_end_state", st0, 0);
        chk("brk_end_line", line0, 1);
        chk("brk_end_done", done0, 0);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_mike_frame_ctrl.md
Name: uart_mike_frame_ctrl

Overview:
Parametrised half-duplex UART frame controller, the successor to the fixed 8-bit control FSM. It owns the TX serialiser: start bit, DATA_WIDTH data bits LSB-first, optional parity, and 1 or 2 stop bits, all paced by an external baud strobe. It also sequences the RX handshake (start, done, flag-clear). It sits between the baud generator, the RX sampler and the host register interface.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal 5..9.
STOP_BITS, 1, stop bits per frame; legal 1 or 2.
PARITY_MODE, 0, parity: 0 none, 1 even, 2 odd.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
baud_tick  input  1  one-cycle strobe, one per bit period
tx_send  input  1  level request; hold until tx_busy=1
tx_data  input  DATA_WIDTH  frame payload; sampled at acceptance
rx_start  input  1  pulse from the RX sampler: start bit detected
rx_done  input  1  pulse from the RX sampler: frame received
rx_flag_clr  input  1  pulse from the host: RX data consumed
tx_line  output  1  serial TX line; idle high
tx_busy  output  1  high from acceptance until the frame ends
tx_done  output  1  one-cycle pulse when the last stop bit ends
rx_busy  output  1  high in RX_DATA
rx_flag  output  1  high in WAIT_FLG_CLR
state_dbg  output  3  current state encoding

Behaviour:
- Clock and reset: single clock domain; n_rst is asynchronous and active-low. All outputs are registered.
- Reset values: state=IDLE, tx_line=1, tx_busy=0, tx_done=0, rx_busy=0, rx_flag=0, counters=0. Reset mid-frame aborts immediately; the line returns high and no tx_done is issued.
- State encoding: IDLE=0, RX_DATA=1, WAIT_FLG_CLR=2, TX_START=3, TX_DATA=4, TX_PARITY=5, TX_STOP=6.
- IDLE:
  - rx_start has priority and moves to RX_DATA with no baud_tick required.
  - Otherwise, tx_send & baud_tick accepts the request: tx_data loads into the shift register, parity is computed, and the FSM moves to TX_START.
  - tx_send without baud_tick waits in IDLE.
- RX_DATA: rx_done moves to WAIT_FLG_CLR. rx_flag_clr is ignored here, including when it coincides with rx_done.
- WAIT_FLG_CLR: rx_flag_clr moves to IDLE. rx_start and tx_send are ignored.
- TX_START: tx_line=0. The next baud_tick moves to TX_DATA.
- TX_DATA:
  - tx_line = shift[0]. On each baud_tick: shift right, bit_cnt+1.
  - On the tick with bit_cnt==DATA_WIDTH-1: go to TX_PARITY if PARITY_MODE!=0, else TX_STOP; bit_cnt clears.
- TX_PARITY: tx_line = XOR of data (even) or its inverse (odd). The next tick moves to TX_STOP.
- TX_STOP:
  - tx_line=1. stop_cnt increments per tick.
  - On the tick with stop_cnt==STOP_BITS-1: go to IDLE, pulse tx_done for one cycle, clear counters.
- Frame timing: every bit lasts exactly one baud period.
- Latency: tx_line changes on the clk edge after the accepting or advancing tick.
- Frame length in ticks = 1 + DATA_WIDTH + (PARITY_MODE!=0) + STOP_BITS.
- tx_busy=1 in TX_START..TX_STOP. tx_send and rx_start are ignored while busy; the design is half-duplex. Changes to tx_data after acceptance have no effect.
- Back-to-back frames: tx_send held high through tx_done is re-accepted on the next baud_tick in IDLE. The minimum inter-frame gap is one bit period of idle-high.
- Illegal parameters (DATA_WIDTH outside 5..9, STOP_BITS not 1/2, PARITY_MODE>2) trigger an elaboration-time error.

Optional Feature:
UART_MIKE_TX_BREAK_EN:
- Defined:
  - Adds input tx_break (1 bit) and state TX_BREAK=7.
  - In IDLE, tx_break (priority below rx_start, above tx_send) enters TX_BREAK. tx_line=0 and tx_busy=1 while tx_break stays high.
  - On tx_break deasserting, return to IDLE with tx_line=1 next cycle; no tx_done is issued.
- Not defined: no tx_break port; encoding 7 is unreachable.

Test Plan:
- DATA_WIDTH=8, PARITY_MODE=0, STOP_BITS=1, tx_data=0xA5, tx_send held until tx_busy -> tx_line per tick = 0,1,0,1,0,0,1,0,1,1; tx_done pulse after tick 10; tx_busy low next cycle.
- PARITY_MODE=2, STOP_BITS=2, DATA_WIDTH=7, tx_data=0x03 -> parity bit=1, two stop bits, frame = 11 ticks.
- rx_start and tx_send asserted together in IDLE with baud_tick -> state_dbg=1, tx_line stays 1; rx_done and rx_flag_clr in the same cycle -> state_dbg=2; a later rx_flag_clr -> state_dbg=0.
- n_rst asserted during TX_DATA bit 3 -> tx_line=1, tx_busy=0, state_dbg=0 asynchronously; no tx_done; the next frame is correct.
- tx_send held continuously for two frames -> exactly one idle-high bit period between the last stop bit and the next start bit.
- UART_MIKE_TX_BREAK_EN defined, tx_break high 25 ticks in IDLE -> tx_line=0 for 25 ticks, state_dbg=7, then 1; with the macro undefined the port is absent.
